// File: rtl/h_ram_rdctl.sv
// ---------------------------------------------------------------------------
// h_ram_rdctl
//
// Read controller that sits between a request/response stream and a
// synchronous RAM with a fixed read latency. Each accepted request is issued
// to the RAM in the same cycle. The returning word is captured into a small
// response buffer and handed to the consumer in request order.
//
// Flow control is credit based. A credit is taken when a request is accepted
// and returned when its response is popped. Because every outstanding read
// therefore owns a buffer slot, the buffer can never overflow. This lets the
// RAM side run without any backpressure of its own.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous, active-high reset
//   req_vld   : a read request is present
//   req_addr  : read address
//   req_rdy   : controller can accept a request (credit available)
//   ram_en    : RAM read enable (req_vld & req_rdy, combinational)
//   ram_addr  : RAM read address (req_addr, combinational)
//   ram_dout  : RAM read data, valid RD_LAT cycles after ram_en
//   rsp_vld   : response buffer is non-empty
//   rsp_data  : response buffer head
//   rsp_rdy   : consumer accepts the response
//   busy      : a read is in flight or the buffer holds data
//
// Parameters
//   ADDR_W : RAM address width
//   DATA_W : RAM data width
//   RD_LAT : RAM read latency in cycles (1 or 2)
//   OBUF_N : response buffer depth (power of two, >= 2)
// ---------------------------------------------------------------------------
module h_ram_rdctl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int OBUF_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_rdy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_rdy,
    output logic              busy
);

    localparam int PTR_W = $clog2(OBUF_N);
    localparam int CNT_W = $clog2(OBUF_N + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(OBUF_N);

    logic [CNT_W-1:0]  credit;
    logic [RD_LAT:1]   vld_p;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [OBUF_N];

    logic accept;
    logic pop;
    logic push;
    logic fifo_full;

    // -----------------------------------------------------------------------
    // Request side. req_rdy depends only on the registered credit count.
    // It is held low while reset is asserted, because an empty credit count
    // alone would otherwise read as "ready" during reset.
    // -----------------------------------------------------------------------
    assign req_rdy  = ~rst & (credit < CREDIT_MAX);
    assign accept   = req_vld & req_rdy;
    assign ram_en   = accept;
    assign ram_addr = req_addr;

    assign rsp_vld  = (fifo_cnt != '0);
    assign pop      = rsp_vld & rsp_rdy;
    assign busy     = (credit != '0);

    // Credit count: outstanding reads plus buffered responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= '0;
        end else if (accept && !pop) begin
            credit <= credit + CNT_W'(1);
        end else if (!accept && pop) begin
            credit <= credit - CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Stage boundary: RAM latency tracking. vld_p[k] is set when the read
    // issued k cycles ago is still alive. vld_p[RD_LAT] marks ram_dout as
    // valid in the current cycle. Clearing this on reset is what discards
    // reads that return after a reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[1] <= accept;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign push = vld_p[RD_LAT];

    // -----------------------------------------------------------------------
    // Stage boundary: response buffer. The pointers wrap naturally because
    // the depth is a power of two. Full and empty are told apart by the
    // occupancy count, not by comparing pointers.
    // -----------------------------------------------------------------------
    assign fifo_full = (fifo_cnt == CREDIT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // Storage is data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ram_dout;
        end
    end

    // The head is read from registered storage, so there is no path from
    // ram_dout to rsp_data. The head holds while the consumer stalls.
    assign rsp_data = mem[rd_ptr];

    // A push into a full buffer would mean the credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_h_ram_rdctl.sv
module tb_h_ram_rdctl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int OBUF_N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_vld = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_rdy;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              rsp_vld;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_rdy = 1'b0;
    logic              busy;

    h_ram_rdctl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT),
        .OBUF_N(OBUF_N)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_addr(req_addr),
        .req_rdy (req_rdy),
        .ram_en  (ram_en),
        .ram_addr(ram_addr),
        .ram_dout(ram_dout),
        .rsp_vld (rsp_vld),
        .rsp_data(rsp_data),
        .rsp_rdy (rsp_rdy),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // RAM model: registered read with a two-cycle latency.
    logic [DATA_W-1:0] ram_arr [256];
    logic [DATA_W-1:0] ram_p1;
    logic [DATA_W-1:0] ram_p2;

    always @(posedge clk) begin
        if (ram_en) ram_p1 <= ram_arr[ram_addr];
        ram_p2 <= ram_p1;
    end
    assign ram_dout = ram_p2;

    // Reference model. Each accepted read becomes visible RD_LAT+1 cycles
    // later. Responses leave in order, and each one holds a credit until
    // it is popped.
    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } ent_t;

    ent_t q[$];
    int   credit  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, want);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a falling edge, with the inputs for this cycle already driven.
    task automatic step();
        logic exp_rdy, exp_vld, acc, pp;
        #1;
        exp_rdy = (credit < OBUF_N);
        exp_vld = (q.size() != 0) && (q[0].due <= cyc);
        acc     = req_vld && exp_rdy;
        pp      = exp_vld && rsp_rdy;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        chk("busy",    64'(busy),    64'(credit != 0));
        chk("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
        chk("ram_en",  64'(ram_en),  64'(acc));
        if (acc)     chk("ram_addr", 64'(ram_addr), 64'(req_addr));
        if (exp_vld) chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
        if (pp) void'(q.pop_front());
        if (acc) begin
            q.push_back('{data: ram_arr[req_addr], due: cyc + RD_LAT + 1});
            acc_cnt++;
        end
        credit = credit + int'(acc) - int'(pp);
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset part-way through a cycle and checks that the outputs
    // drop at once, without waiting for a clock edge.
    task automatic reset_mid();
        rst = 1'b1;
        #1;
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_ram_en",  64'(ram_en),  64'd0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        q.delete();
        credit = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 256; i++) ram_arr[i] = $urandom;
        ram_arr[8'h10] = 32'hDEADBEEF;

        // Reset state, with a request present to show that ram_en stays low.
        rst = 1'b1; req_vld = 1'b1; req_addr = 8'h55; rsp_rdy = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        chk("init_req_rdy", 64'(req_rdy), 64'd0);
        chk("init_ram_en",  64'(ram_en),  64'd0);
        chk("init_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("init_busy",    64'(busy),    64'd0);
        @(negedge clk);
        rst = 1'b0; req_vld = 1'b0;

        // Single read of address 0x10.
        req_vld = 1'b1; req_addr = 8'h10; rsp_rdy = 1'b1;
        step();
        req_vld = 1'b0;
        repeat (5) step();

        // Back-to-back stream to addresses 0..15 with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            req_vld = 1'b1; req_addr = ADDR_W'(i); rsp_rdy = 1'b1;
            step();
        end
        req_vld = 1'b0;
        repeat (6) step();

        // Backpressure: the consumer is stalled and requests are continuous.
        acc0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            req_vld = 1'b1; req_addr = ADDR_W'(8'h20 + i); rsp_rdy = 1'b0;
            step();
        end
        chk("bp_accepts", 64'(acc_cnt - acc0), 64'd4);
        rsp_rdy = 1'b1; step();
        rsp_rdy = 1'b0; step();
        // Accept and pop together while one credit is free.
        for (int i = 0; i < 8; i++) begin
            req_vld = 1'b1; req_addr = ADDR_W'(8'h30 + i); rsp_rdy = 1'b1;
            step();
        end
        req_vld = 1'b0;
        repeat (8) step();

        // Reset mid-stream: two reads in flight and two responses buffered.
        for (int i = 0; i < 4; i++) begin
            req_vld = 1'b1; req_addr = ADDR_W'(8'h40 + i); rsp_rdy = 1'b0;
            step();
        end
        reset_mid();
        req_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (6) step();

        // Random traffic, with occasional resets.
        for (int c = 0; c < 10000; c++) begin
            req_vld  = ($urandom_range(3) != 0);
            req_addr = ADDR_W'($urandom);
            rsp_rdy  = (c % 2000 < 1000) ? ($urandom_range(2) != 0) : ($urandom_range(3) == 0);
            if ($urandom_range(999) == 0) begin
                reset_mid();
            end else begin
                step();
            end
        end
        req_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
